// File: rtl/qracc_csr.sv
// qracc_csr: bus-slave control/status registers for the QRAcc layer sequencer.
// Define QRACC_CSR_SHADOW_EN for a double-buffered config (shadow -> active on commit).
package qracc_csr_pkg;
  typedef struct packed {
    logic [3:0]  n_input_bits_cfg;
    logic [3:0]  n_output_bits_cfg;
    logic        binary_cfg;
    logic        unsigned_acts;
    logic [2:0]  adc_ref_range_shifts;
    logic [3:0]  filter_size_y;
    logic [3:0]  filter_size_x;
    logic [31:0] input_fmap_size;
    logic [31:0] output_fmap_size;
    logic [31:0] input_fmap_dimx;
    logic [31:0] input_fmap_dimy;
    logic [31:0] output_fmap_dimx;
    logic [31:0] output_fmap_dimy;
    logic [9:0]  num_input_channels;
    logic [9:0]  num_output_channels;
    logic [9:0]  mapped_matrix_offset_x;
    logic [9:0]  mapped_matrix_offset_y;
  } qracc_config_t;
endpackage

module qracc_csr
  import qracc_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h51AC_0001
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [31:0]   bus_data_i,
  input  logic [31:0]   bus_addr_i,
  input  logic          bus_wen_i,
  input  logic          bus_valid_i,
  output logic          bus_ready_o,
  output logic [31:0]   bus_read_data_o,
  output qracc_config_t cfg_o,
  output logic          cfg_valid_o,
  output logic          start_o,
  input  logic          busy_i,
  input  logic          done_i
);

  localparam logic [3:0] IDX_CTRL   = 4'd0;
  localparam logic [3:0] IDX_STATUS = 4'd1;
  localparam logic [3:0] IDX_ID     = 4'd13;

  function automatic logic [31:0] cfg_read(input qracc_config_t c, input logic [3:0] idx);
    logic [31:0] r;
    r = '0;
    case (idx)
      4'd2:  r = {19'd0, c.adc_ref_range_shifts, c.unsigned_acts, c.binary_cfg,
                  c.n_output_bits_cfg, c.n_input_bits_cfg};
      4'd3:  r = {24'd0, c.filter_size_x, c.filter_size_y};
      4'd4:  r = c.input_fmap_size;
      4'd5:  r = c.output_fmap_size;
      4'd6:  r = c.input_fmap_dimx;
      4'd7:  r = c.input_fmap_dimy;
      4'd8:  r = {22'd0, c.num_input_channels};
      4'd9:  r = c.output_fmap_dimx;
      4'd10: r = c.output_fmap_dimy;
      4'd11: r = {22'd0, c.num_output_channels};
      4'd12: r = {6'd0, c.mapped_matrix_offset_y, 6'd0, c.mapped_matrix_offset_x};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic qracc_config_t cfg_write(input qracc_config_t c, input logic [3:0] idx,
                                              input logic [31:0] d);
    qracc_config_t r;
    r = c;
    case (idx)
      4'd2: begin
        r.n_input_bits_cfg     = d[3:0];
        r.n_output_bits_cfg    = d[7:4];
        r.binary_cfg           = d[8];
        r.unsigned_acts        = d[9];
        r.adc_ref_range_shifts = d[12:10];
      end
      4'd3: begin
        r.filter_size_y = d[3:0];
        r.filter_size_x = d[7:4];
      end
      4'd4:  r.input_fmap_size     = d;
      4'd5:  r.output_fmap_size    = d;
      4'd6:  r.input_fmap_dimx     = d;
      4'd7:  r.input_fmap_dimy     = d;
      4'd8:  r.num_input_channels  = d[9:0];
      4'd9:  r.output_fmap_dimx    = d;
      4'd10: r.output_fmap_dimy    = d;
      4'd11: r.num_output_channels = d[9:0];
      4'd12: begin
        r.mapped_matrix_offset_x = d[9:0];
        r.mapped_matrix_offset_y = d[25:16];
      end
      default: ;
    endcase
    return r;
  endfunction

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state_reg, state_next;
  qracc_config_t active_reg, active_next, cfg_src;
  logic [31:0]   rdata_reg, rdata_next;
  logic          start_reg, start_next;
  logic          cfg_valid_reg, cfg_valid_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          start_err, cfg_err, commit_pending;

`ifdef QRACC_CSR_SHADOW_EN
  qracc_config_t shadow_reg, shadow_next;
  logic          pending_reg, pending_next;
  logic          pstart_reg, pstart_next;
  logic          commit_now;
  assign commit_pending = pending_reg;
`else
  assign commit_pending = 1'b0;
`endif

  logic [3:0] idx;
  logic       accept, mapped, rd_req, wr_req;
  logic       ctrl_wr, status_wr, cfg_wr, commit_req, start_req;

  assign idx        = bus_addr_i[5:2];
  assign accept     = (state_reg == IDLE) && bus_valid_i;
  assign mapped     = (bus_addr_i[1:0] == 2'b00) && (bus_addr_i[31:6] == 26'd0) && (idx <= IDX_ID);
  assign rd_req     = accept && !bus_wen_i;
  assign wr_req     = accept && bus_wen_i;
  assign ctrl_wr    = wr_req && mapped && (idx == IDX_CTRL);
  assign status_wr  = wr_req && mapped && (idx == IDX_STATUS);
  assign cfg_wr     = wr_req && mapped && (idx >= 4'd2) && (idx <= 4'd12);
  assign commit_req = ctrl_wr && bus_data_i[0];
  assign start_req  = ctrl_wr && bus_data_i[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus_valid_i) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    active_next    = active_reg;
    cfg_valid_next = cfg_valid_reg;
`ifdef QRACC_CSR_SHADOW_EN
    cfg_src     = shadow_reg;
    shadow_next = shadow_reg;
    if (cfg_wr) shadow_next = cfg_write(shadow_reg, idx, bus_data_i);
    // A commit seen while busy waits; it copies whatever the shadow holds when busy drops.
    commit_now   = (commit_req || pending_reg) && !busy_i;
    pending_next = (commit_req || pending_reg) && busy_i;
    pstart_next  = pending_next && (pstart_reg || (commit_req && start_req));
    start_next   = !busy_i && (start_req || (pending_reg && pstart_reg));
    start_err    = start_req && !commit_req && busy_i;
    cfg_err      = 1'b0;
    if (commit_now) begin
      active_next    = shadow_reg;
      cfg_valid_next = 1'b1;
    end
`else
    cfg_src = active_reg;
    if (cfg_wr && !busy_i) active_next = cfg_write(active_reg, idx, bus_data_i);
    if (commit_req) cfg_valid_next = 1'b1;
    start_next = start_req && !busy_i;
    start_err  = start_req && busy_i;
    cfg_err    = cfg_wr && busy_i;
`endif
    err_next  = (accept && !mapped) || start_err || cfg_err ||
                (err_reg && !(status_wr && bus_data_i[3]));
    done_next = done_i || (done_reg && !(status_wr && bus_data_i[2]));

    rdata_next = '0;
    if (rd_req && mapped) begin
      case (idx)
        IDX_STATUS: rdata_next = {28'd0, err_reg, done_reg, commit_pending, busy_i};
        IDX_ID:     rdata_next = ID_VALUE;
        default:    rdata_next = cfg_read(cfg_src, idx);
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      active_reg    <= '0;
      rdata_reg     <= '0;
      start_reg     <= 1'b0;
      cfg_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
`ifdef QRACC_CSR_SHADOW_EN
      shadow_reg    <= '0;
      pending_reg   <= 1'b0;
      pstart_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      active_reg    <= active_next;
      rdata_reg     <= rdata_next;
      start_reg     <= start_next;
      cfg_valid_reg <= cfg_valid_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
`ifdef QRACC_CSR_SHADOW_EN
      shadow_reg    <= shadow_next;
      pending_reg   <= pending_next;
      pstart_reg    <= pstart_next;
`endif
    end
  end

  assign bus_ready_o     = (state_reg == RESP);
  assign bus_read_data_o = rdata_reg;
  assign cfg_o           = active_reg;
  assign cfg_valid_o     = cfg_valid_reg;
  assign start_o         = start_reg;

endmodule

// File: tb/tb_qracc_csr.sv
// Self-checking bench for qracc_csr: directed table, corner sequences, and randomized
// transactions against a word-level register model (follows QRACC_CSR_SHADOW_EN).
module tb_qracc_csr;
  import qracc_csr_pkg::*;

`ifdef QRACC_CSR_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam logic [31:0] ID = 32'h51AC_0001;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [31:0]   bus_data_i = '0;
  logic [31:0]   bus_addr_i = '0;
  logic          bus_wen_i = 1'b0;
  logic          bus_valid_i = 1'b0;
  logic          bus_ready_o;
  logic [31:0]   bus_read_data_o;
  qracc_config_t cfg_o;
  logic          cfg_valid_o;
  logic          start_o;
  logic          busy_i = 1'b0;
  logic          done_i = 1'b0;

  qracc_csr dut (
    .clk(clk), .nrst(nrst),
    .bus_data_i(bus_data_i), .bus_addr_i(bus_addr_i), .bus_wen_i(bus_wen_i),
    .bus_valid_i(bus_valid_i), .bus_ready_o(bus_ready_o), .bus_read_data_o(bus_read_data_o),
    .cfg_o(cfg_o), .cfg_valid_o(cfg_valid_o), .start_o(start_o),
    .busy_i(busy_i), .done_i(done_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int start_seen = 0;
  always @(negedge clk) if (start_o) start_seen++;

  // Register model: one 32-bit word per register index, masked to the implemented bits.
  logic [31:0] mask     [0:15];
  logic [31:0] m_shadow [0:15];
  logic [31:0] m_active [0:15];
  bit m_valid, m_pend, m_pstart, m_done, m_err;
  int m_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_valid = 0; m_pend = 0; m_pstart = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_commit();
    for (int i = 2; i <= 12; i++) m_active[i] = m_shadow[i];
    m_valid = 1;
    if (m_pstart) m_starts++;
    m_pend = 0;
    m_pstart = 0;
  endtask

  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic busy, input bit dp, output logic [31:0] exp);
    logic [3:0] idx;
    bit mapped;
    idx = a[5:2];
    mapped = (a[1:0] == 2'b00) && (a[31:6] == 26'd0) && (idx <= 4'd13);
    exp = '0;
    if (!mapped) m_err = 1;
    else if (!w) begin
      if (idx == 4'd1) exp = {28'd0, m_err, m_done, m_pend, busy};
      else if (idx == 4'd13) exp = ID;
      else if (idx >= 4'd2 && idx <= 4'd12) exp = SHADOW ? m_shadow[idx] : m_active[idx];
    end else if (idx == 4'd1) begin
      if (d[2]) m_done = 0;
      if (d[3]) m_err = 0;
    end else if (idx >= 4'd2 && idx <= 4'd12) begin
      if (SHADOW) m_shadow[idx] = d & mask[idx];
      else if (busy) m_err = 1;
      else m_active[idx] = d & mask[idx];
    end else if (idx == 4'd0) begin
      if (SHADOW && d[0]) begin
        m_pend = 1;
        m_pstart = m_pstart | d[1];
      end else begin
        if (d[0]) m_valid = 1;
        if (d[1]) begin
          if (busy) m_err = 1;
          else m_starts++;
        end
      end
    end
    if (dp) m_done = 1;
    if (m_pend && !busy) model_commit();
  endtask

  function automatic logic [31:0] dut_word(input logic [3:0] idx);
    case (idx)
      4'd2:  return {19'd0, cfg_o.adc_ref_range_shifts, cfg_o.unsigned_acts, cfg_o.binary_cfg,
                     cfg_o.n_output_bits_cfg, cfg_o.n_input_bits_cfg};
      4'd3:  return {24'd0, cfg_o.filter_size_x, cfg_o.filter_size_y};
      4'd4:  return cfg_o.input_fmap_size;
      4'd5:  return cfg_o.output_fmap_size;
      4'd6:  return cfg_o.input_fmap_dimx;
      4'd7:  return cfg_o.input_fmap_dimy;
      4'd8:  return {22'd0, cfg_o.num_input_channels};
      4'd9:  return cfg_o.output_fmap_dimx;
      4'd10: return cfg_o.output_fmap_dimy;
      4'd11: return {22'd0, cfg_o.num_output_channels};
      4'd12: return {6'd0, cfg_o.mapped_matrix_offset_y, 6'd0, cfg_o.mapped_matrix_offset_x};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_state(input string name);
    int bad;
    bad = 6;
    for (int i = 12; i >= 2; i--) if (dut_word(4'(i)) !== m_active[i]) bad = i;
    check({name, "_cfg"}, dut_word(4'(bad)), m_active[bad]);
    check({name, "_cfg_valid"}, {31'd0, cfg_valid_o}, {31'd0, m_valid});
    check({name, "_starts"}, 32'(start_seen), 32'(m_starts));
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit dp, output logic [31:0] rd);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    bus_valid_i = 1'b1; bus_wen_i = w; bus_addr_i = a; bus_data_i = d; done_i = dp;
    model_apply(w, a, d, busy_i, dp, exp);
    @(posedge clk); #1;
    done_i = 1'b0;
    n = 1;
    while (!bus_ready_o && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_latency", 32'(n), 32'd1);
    rd = bus_read_data_o;
    if (!w) check("rdata_model", rd, exp);
    bus_valid_i = 1'b0; bus_wen_i = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, bus_ready_o}, 32'd0);
    check_state("xfer");
  endtask

  task automatic set_busy(input logic b);
    @(negedge clk);
    busy_i = b;
    if (m_pend && !b) model_commit();
    @(posedge clk);
    @(negedge clk); #1;
    check_state("busy");
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [0:22];
  logic [31:0] alist [0:17];

  initial begin
    logic [31:0] rd;
    int s0;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int s0;
    mask = '{32'h0, 32'h0, 32'h1FFF, 32'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 32'h3FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3FF, 32'h03FF_03FF,
             32'h0, 32'h0, 32'h0};
    tbl = '{
      '{1'b0, 32'h34, 32'h0,          ID},
      '{1'b1, 32'h18, 32'h20,         32'h0},
      '{1'b0, 32'h18, 32'h0,          32'h20},
      '{1'b1, 32'h08, 32'hFFFF_FFFF,  32'h0},
      '{1'b0, 32'h08, 32'h0,          32'h1FFF},
      '{1'b1, 32'h30, 32'hFFFF_FFFF,  32'h0},
      '{1'b0, 32'h30, 32'h0,          32'h03FF_03FF},
      '{1'b1, 32'h0C, 32'hFFFF_FFFF,  32'h0},
      '{1'b0, 32'h0C, 32'h0,          32'hFF},
      '{1'b1, 32'h20, 32'hFFFF_FFFF,  32'h0},
      '{1'b0, 32'h20, 32'h0,          32'h3FF},
      '{1'b0, 32'h00, 32'h0,          32'h0},
      '{1'b1, 32'h3C, 32'h1,          32'h0},
      '{1'b0, 32'h04, 32'h0,          32'h8},
      '{1'b0, 32'h3C, 32'h0,          32'h0},
      '{1'b1, 32'h04, 32'h8,          32'h0},
      '{1'b0, 32'h04, 32'h0,          32'h0},
      '{1'b1, 32'h1A, 32'h5,          32'h0},
      '{1'b0, 32'h04, 32'h0,          32'h8},
      '{1'b1, 32'h04, 32'h8,          32'h0},
      '{1'b1, 32'h34, 32'h123,        32'h0},
      '{1'b0, 32'h04, 32'h0,          32'h0},
      '{1'b0, 32'h34, 32'h0,          ID}
    };
    alist = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
              32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h1A, 32'h40};
    model_reset();

    // Reset: every output low.
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, bus_ready_o}, 32'd0);
    check("reset_rdata", bus_read_data_o, 32'd0);
    check("reset_start", {31'd0, start_o}, 32'd0);
    check("reset_cfg_valid", {31'd0, cfg_valid_o}, 32'd0);
    check("reset_cfg_zero", {31'd0, (cfg_o != '0)}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Directed register-map table.
    for (int i = 0; i <= 22; i++) begin
      xfer(tbl[i].w, tbl[i].addr, tbl[i].data, 1'b0, rd);
      if (!tbl[i].w) check($sformatf("table_%0d", i), rd, tbl[i].exp);
      $display("txn table %0d w=%0d addr=0x%02h data=0x%08h rd=0x%08h", i, tbl[i].w,
               tbl[i].addr, tbl[i].data, rd);
    end

    // Commit.
    check("dimx_before_commit", cfg_o.input_fmap_dimx, SHADOW ? 32'h0 : 32'h20);
    xfer(1'b1, 32'h00, 32'h1, 1'b0, rd);
    check("dimx_after_commit", cfg_o.input_fmap_dimx, 32'h20);
    check("cfg_valid_after_commit", {31'd0, cfg_valid_o}, 32'd1);
    $display("txn commit dimx=0x%08h cfg_valid=%0d", cfg_o.input_fmap_dimx, cfg_valid_o);

    // Commit+start while busy.
    s0 = start_seen;
    set_busy(1'b1);
    xfer(1'b1, 32'h18, 32'h40, 1'b0, rd);
    xfer(1'b1, 32'h00, 32'h3, 1'b0, rd);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd);
    check("status_busy_commit", rd, SHADOW ? 32'h3 : 32'h9);
    check("no_start_while_busy", 32'(start_seen - s0), 32'd0);
    set_busy(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("start_after_busy", 32'(start_seen - s0), SHADOW ? 32'd1 : 32'd0);
    check("dimx_after_pending", cfg_o.input_fmap_dimx, SHADOW ? 32'h40 : 32'h20);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd);
    check("status_after_pending", rd, SHADOW ? 32'h0 : 32'h8);
    xfer(1'b1, 32'h04, 32'h8, 1'b0, rd);
    $display("txn busy-commit sequence starts=%0d", start_seen - s0);

    // Start alone while idle.
    s0 = start_seen;
    xfer(1'b1, 32'h00, 32'h2, 1'b0, rd);
    check("start_alone_idle", 32'(start_seen - s0), 32'd1);

    // done_i set beats W1C on the same edge.
    xfer(1'b0, 32'h04, 32'h0, 1'b1, rd);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd);
    check("done_sticky_set", rd, 32'h4);
    xfer(1'b1, 32'h04, 32'h4, 1'b1, rd);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd);
    check("done_set_wins_w1c", rd, 32'h4);
    xfer(1'b1, 32'h04, 32'h4, 1'b0, rd);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd);
    check("done_w1c_clears", rd, 32'h0);
    $display("txn done sticky sequence status=0x%08h", rd);

    // Reset during the RESP cycle with a commit pending.
    set_busy(1'b1);
    xfer(1'b1, 32'h00, 32'h3, 1'b0, rd);
    @(negedge clk);
    bus_valid_i = 1'b1; bus_wen_i = 1'b0; bus_addr_i = 32'h04;
    @(posedge clk); #1;
    check("resp_before_reset", {31'd0, bus_ready_o}, 32'd1);
    nrst = 1'b0;
    #1;
    check("reset_mid_ready", {31'd0, bus_ready_o}, 32'd0);
    check("reset_mid_cfg_valid", {31'd0, cfg_valid_o}, 32'd0);
    check("reset_mid_cfg_zero", {31'd0, (cfg_o != '0)}, 32'd0);
    bus_valid_i = 1'b0;
    busy_i = 1'b0;
    s0 = start_seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("no_start_after_reset", 32'(start_seen - s0), 32'd0);
    xfer(1'b0, 32'h04, 32'h0, 1'b0, rd);
    check("status_after_reset", rd, 32'h0);
    $display("txn reset-mid-transaction status=0x%08h", rd);

    // Randomized transactions against the model.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        set_busy(1'($urandom_range(0, 1)));
        $display("txn rand %0d busy=%0d", k, busy_i);
      end else begin
        logic [31:0] a, d;
        logic w;
        bit dp;
        a = alist[$urandom_range(0, 17)];
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        if (a == 32'h0) d = d & 32'h3;
        dp = ($urandom_range(0, 9) == 0);
        xfer(w, a, d, dp, rd);
        $display("txn rand %0d w=%0d addr=0x%02h data=0x%08h done=%0d rd=0x%08h", k, w, a,
                 d, dp, rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
